apb_reg_initiator: RTL and testbench

- Drives the other end of the APB register interface that blocks such as blockA expose as `apb_if.dst`.
- Accepts single register read/write commands on a four-phase req/ack command port, runs one APB transfer (setup then access), and returns read data and an error flag.
- Times out hung transfers.
- Sits between a test/config sequencer or CPU-side bridge and the APB completer ports of the design's blocks.

---
 rtl/apb_reg_initiator.sv | 128 ++++++++++++
 tb/tb_apb_reg_initiator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_initiator.sv
// APB register initiator: turns one four-phase req/ack command into a single
// APB transfer (SETUP then ACCESS), returns read data and an error flag,
// abandons transfers whose completer never raises pready, and keeps a
// saturating count of errored transfers.
module apb_reg_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_req,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ack,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic              apb_pready,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pslverr,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit so a
  // disabled or tiny timeout still elaborates.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t            r_state;
  logic [TW-1:0]     r_tmo_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic              r_ack;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic              w_timeout;
  logic              w_finish;
  logic              w_end_err;

  // pready wins over a timeout that lands on the same cycle.
  assign w_timeout = TMO_EN && (r_tmo_cnt == TMO_LAST);
  assign w_finish  = apb_pready || w_timeout;
  assign w_end_err = apb_pready ? apb_pslverr : 1'b1;

  // Transfer sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_req) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
            r_psel   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_finish) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ack     <= 1'b1;
            r_err     <= w_end_err;
            r_rdata   <= (!w_end_err && !r_pwrite) ? apb_prdata : '0;
            if (w_end_err && (r_err_cnt != 8'hFF))
              r_err_cnt <= r_err_cnt + 8'd1;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // Late pready from a timed-out completer lands here and is ignored.
          if (!cmd_req) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ack     = r_ack;
  assign cmd_rdata   = r_rdata;
  assign cmd_err     = r_err;
  assign apb_paddr   = r_paddr;
  assign apb_psel    = r_psel;
  assign apb_penable = r_penable;
  assign apb_pwrite  = r_pwrite;
  assign apb_pwdata  = r_pwdata;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_apb_reg_initiator.sv
// Bench for apb_reg_initiator: a transaction-level timeline model of the
// expected outputs, checked every cycle, plus literal spot checks.
module tb_apb_reg_initiator;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_req = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ack, cmd_err;
  logic [DW-1:0] cmd_rdata;
  logic [AW-1:0] apb_paddr;
  logic          apb_psel, apb_penable, apb_pwrite;
  logic [DW-1:0] apb_pwdata;
  logic          apb_pready = 1'b0, apb_pslverr = 1'b0;
  logic [DW-1:0] apb_prdata = '0;
  logic [7:0]    err_count;

  apb_reg_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_req(cmd_req), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .cmd_err(cmd_err), .apb_paddr(apb_paddr), .apb_psel(apb_psel),
    .apb_penable(apb_penable), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
    .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int ack_rise_cyc = -1;
  logic prev_ack = 1'b0;
  bit chk_en = 1'b0;

  // Expected output values after the most recent rising edge.
  logic          m_psel = 0, m_pen = 0, m_pwrite = 0, m_ack = 0, m_err = 0;
  logic [AW-1:0] m_paddr = '0;
  logic [DW-1:0] m_pwdata = '0, m_rdata = '0;
  int            m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("psel",      apb_psel,    m_psel);
      chk("penable",   apb_penable, m_pen);
      chk("paddr",     apb_paddr,   m_paddr);
      chk("pwrite",    apb_pwrite,  m_pwrite);
      chk("pwdata",    apb_pwdata,  m_pwdata);
      chk("cmd_ack",   cmd_ack,     m_ack);
      chk("cmd_err",   cmd_err,     m_err);
      chk("cmd_rdata", cmd_rdata,   m_rdata);
      chk("err_count", err_count,   m_cnt[7:0]);
    end
    if (cmd_ack === 1'b1 && prev_ack !== 1'b1) ack_rise_cyc <= cyc;
    prev_ack <= cmd_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_psel = 0; m_pen = 0; m_pwrite = 0; m_ack = 0; m_err = 0;
    m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_cnt = 0;
  endtask

  // One command. waits = wait states before pready (<0 or >=TMO: hang and
  // time out). hold = cycles req stays high after ack. Returns the ack
  // latency in edges from req rise and the rdata/err seen while ack is high.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input bit slverr, input logic [DW-1:0] prd,
                      input int hold, output int lat, output logic [DW-1:0] got_rd,
                      output logic got_err);
    bit tmo;
    int acc_len, req_cyc;
    tmo = (waits < 0) || (waits >= TMO);
    acc_len = tmo ? TMO : waits + 1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_req = 1'b1;
    req_cyc = cyc;
    step();
    m_psel = 1; m_pen = 0; m_paddr = addr; m_pwrite = wr; m_pwdata = wr ? wdata : '0;
    step();
    m_pen = 1;
    for (int j = 1; j <= acc_len; j++) begin
      if (!tmo && j == acc_len) begin
        apb_pready = 1'b1; apb_pslverr = slverr; apb_prdata = prd;
      end else begin
        apb_pready = 1'b0; apb_pslverr = 1'($urandom_range(0, 1)); apb_prdata = $urandom;
      end
      step();
    end
    apb_pready = 1'b0; apb_pslverr = 1'b0;
    m_psel = 0; m_pen = 0; m_ack = 1;
    m_err = tmo || slverr;
    m_rdata = (!wr && !m_err) ? prd : '0;
    if (m_err && m_cnt < 255) m_cnt++;
    for (int h = 0; h < hold; h++) begin
      apb_pready = (tmo && h == 0);
      apb_prdata = 32'h5555_AAAA;
      step();
    end
    apb_pready = 1'b0;
    got_rd = cmd_rdata; got_err = cmd_err;
    cmd_req = 1'b0;
    step();
    m_ack = 0; m_err = 0; m_rdata = '0;
    lat = (ack_rise_cyc > req_cyc) ? (ack_rise_cyc - req_cyc) : -1;
  endtask

  int lat;
  logic [DW-1:0] rd;
  logic er;

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_psel", apb_psel, 1'b0);
    chk("reset_err_count", err_count, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // write, ready immediately
    xfer(1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1, lat, rd, er);
    chk("wr_latency", lat, 3);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_err", er, 1'b0);

    // read with 3 wait states
    xfer(1'b0, 32'h24, 32'hFFFF_FFFF, 3, 1'b0, 32'hDEAD_BEEF, 1, lat, rd, er);
    chk("rd_latency", lat, 6);
    chk("rd_rdata", rd, 32'hDEAD_BEEF);
    chk("rd_err", er, 1'b0);

    // slave error on a read
    xfer(1'b0, 32'h30, 32'h0, 1, 1'b1, 32'h1234_5678, 0, lat, rd, er);
    chk("slverr_err", er, 1'b1);
    chk("slverr_rdata", rd, 32'h0);
    chk("slverr_count1", err_count, 8'd1);

    // 299 more errors: saturates at 255
    for (int i = 0; i < 299; i++)
      xfer(i[0], 32'h100 + i, 32'hC0DE_0000 + i, i % 3, 1'b1, 32'hABCD_0000 + i, 0, lat, rd, er);
    chk("err_count_sat", err_count, 8'd255);

    // timeout with a late pready pulse during DONE
    xfer(1'b0, 32'h44, 32'h0, -1, 1'b0, 32'h0, 3, lat, rd, er);
    chk("tmo_latency", lat, TMO + 2);
    chk("tmo_err", er, 1'b1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_count_held", err_count, 8'd255);

    // requester holds req for 5 cycles after ack, then back-to-back command
    xfer(1'b1, 32'h50, 32'h1111_2222, 2, 1'b0, 32'h0, 5, lat, rd, er);
    chk("hs_latency", lat, 5);
    xfer(1'b0, 32'h54, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 0, lat, rd, er);
    chk("b2b_rdata", rd, 32'h0BAD_F00D);

    // reset in the middle of ACCESS
    cmd_write = 1'b0; cmd_addr = 32'h60; cmd_req = 1'b1;
    step();
    m_psel = 1; m_pen = 0; m_paddr = 32'h60; m_pwrite = 0; m_pwdata = '0;
    step();
    m_pen = 1; apb_pready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_psel", apb_psel, 1'b0);
    chk("rst_penable", apb_penable, 1'b0);
    chk("rst_ack", cmd_ack, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    cmd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    xfer(1'b0, 32'h64, 32'h0, 1, 1'b0, 32'h7777_0001, 0, lat, rd, er);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_rdata", rd, 32'h7777_0001);
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
